fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_unit_if.sv | 48 ++++
 rtl/fetch_unit_if_id_reg.sv | 34 +++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared processor package for the fetch stage.
// Holds the FSM encoding, bubble/reset constants and the IF/ID bundle.
package fetch_unit_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        valid;
  } if_id_t;

  function automatic logic is_aligned(input logic [31:0] a);
    return (a[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem port, hazard controls, redirect and IF/ID outputs.
// master is the fetch unit, slave is memory/hazard/decode side.
interface fetch_unit_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;
  logic        misalign_trap;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  stall_f,
    input  stall_d,
    input  flush_d,
    input  pc_src_e,
    input  pc_target_e,
    output instr_d,
    output pc_d,
    output pcplus4_d,
    output valid_d,
    output misalign_trap
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output stall_f,
    output stall_d,
    output flush_d,
    output pc_src_e,
    output pc_target_e,
    input  instr_d,
    input  pc_d,
    input  pcplus4_d,
    input  valid_d,
    input  misalign_trap
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register with enable and synchronous bubble clear.
// Clear wins over a disabled enable so a flush is never lost to a stall.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_en,
  input  logic   i_clr,
  input  if_id_t i_d,
  output if_id_t o_q
);

  localparam if_id_t BUBBLE = '{
    instr:   NOP_INSTR,
    pc:      32'h0,
    pcplus4: 32'h0,
    valid:   1'b0
  };

  if_id_t r_q;

  // bubble on reset/clear, otherwise capture when enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_q <= BUBBLE;
    else if (i_clr) r_q <= BUBBLE;
    else if (i_en)  r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC mux and RUN/TRAP FSM.
// A misaligned redirect freezes the PC and bubbles IF/ID until reset.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_C,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] w_pcplus4;
  logic        r_trap;
  logic        w_trap_set;
  logic        w_bubble;
  logic        w_tgt_ok;
  if_id_t      w_fetch;
  if_id_t      w_if_id;

  assign w_pcplus4     = r_pc + 32'd4;
  assign w_tgt_ok      = is_aligned(bus.pc_target_e);
  assign bus.imem_addr = r_pc;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  // FSM next state: a misaligned redirect traps for good
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:
        if (bus.pc_src_e && !w_tgt_ok)
          w_state_next = ST_TRAP;
      ST_TRAP:
        w_state_next = ST_TRAP;
    endcase
  end

  // FSM outputs: next PC, IF/ID bubble, trap set
  always_comb begin
    w_pc_next  = r_pc;
    w_bubble   = 1'b1;
    w_trap_set = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_bubble = bus.flush_d | bus.pc_src_e;
        if (bus.pc_src_e) begin
          if (w_tgt_ok) w_pc_next  = bus.pc_target_e;
          else          w_trap_set = 1'b1;
        end else if (!bus.stall_f) begin
          w_pc_next = w_pcplus4;
        end
      end
      ST_TRAP: begin
        w_pc_next = r_pc;
      end
    endcase
  end

  // PC register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pc <= RESET_PC;
    else       r_pc <= w_pc_next;
  end

  // sticky misalignment flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_trap <= 1'b0;
    else if (w_trap_set) r_trap <= 1'b1;
  end

  assign w_fetch = '{
    instr:   bus.imem_instr,
    pc:      r_pc,
    pcplus4: w_pcplus4,
    valid:   1'b1
  };

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk   (clk),
    .reset (reset),
    .i_en  (~bus.stall_d),
    .i_clr (w_bubble),
    .i_d   (w_fetch),
    .o_q   (w_if_id)
  );

  assign bus.instr_d       = w_if_id.instr;
  assign bus.pc_d          = w_if_id.pc;
  assign bus.pcplus4_d     = w_if_id.pcplus4;
  assign bus.valid_d       = w_if_id.valid;
  assign bus.misalign_trap = r_trap;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus trap/reset sequences.
// Memory model returns 32'hAB00_0000 ^ address.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;

  fetch_unit_if bus ();

  fetch_unit u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.imem_instr = 32'hAB00_0000 ^ bus.imem_addr;

  typedef struct {
    logic        sf;
    logic        sd;
    logic        fl;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] p4;
    logic        v;
  } vec_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  vec_t tv[16];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic sf, input logic sd, input logic fl,
                       input logic br, input logic [31:0] tgt);
    bus.stall_f     = sf;
    bus.stall_d     = sd;
    bus.flush_d     = fl;
    bus.pc_src_e    = br;
    bus.pc_target_e = tgt;
  endtask

  task automatic step(input logic sf, input logic sd, input logic fl,
                      input logic br, input logic [31:0] tgt);
    drive(sf, sd, fl, br, tgt);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_addr"},  bus.imem_addr, 32'h0);
    chk({tag, "_instr"}, bus.instr_d, NOP);
    chk({tag, "_pc"},    bus.pc_d, 32'h0);
    chk({tag, "_p4"},    bus.pcplus4_d, 32'h0);
    chk({tag, "_valid"}, {31'b0, bus.valid_d}, 32'h0);
    chk({tag, "_trap"},  {31'b0, bus.misalign_trap}, 32'h0);
  endtask

  initial begin
    //        sf   sd   fl   br   tgt           addr          instr         pc            p4            v
    tv[0]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,       32'h4,        32'hAB000000, 32'h0,        32'h4,        1'b1};
    tv[1]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,       32'h8,        32'hAB000004, 32'h4,        32'h8,        1'b1};
    tv[2]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,       32'h8,        32'hAB000004, 32'h4,        32'h8,        1'b1};
    tv[3]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,       32'hC,        32'hAB000008, 32'h8,        32'hC,        1'b1};
    tv[4]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,       32'h10,       32'hAB00000C, 32'hC,        32'h10,       1'b1};
    tv[5]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,       32'h14,       32'hAB000010, 32'h10,       32'h14,       1'b1};
    tv[6]  = '{1'b1,1'b0,1'b0,1'b1,32'h40,      32'h40,       NOP,          32'h0,        32'h0,        1'b0};
    tv[7]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,       32'h44,       32'hAB000040, 32'h40,       32'h44,       1'b1};
    tv[8]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,       32'h48,       NOP,          32'h0,        32'h0,        1'b0};
    tv[9]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,       32'h4C,       NOP,          32'h0,        32'h0,        1'b0};
    tv[10] = '{1'b0,1'b0,1'b0,1'b0,32'h0,       32'h50,       32'hAB00004C, 32'h4C,       32'h50,       1'b1};
    tv[11] = '{1'b0,1'b0,1'b0,1'b1,32'hFFFFFFFC,32'hFFFFFFFC, NOP,          32'h0,        32'h0,        1'b0};
    tv[12] = '{1'b0,1'b0,1'b0,1'b0,32'h0,       32'h0,        32'h54FFFFFC, 32'hFFFFFFFC, 32'h0,        1'b1};
    tv[13] = '{1'b0,1'b0,1'b0,1'b0,32'h0,       32'h4,        32'hAB000000, 32'h0,        32'h4,        1'b1};
    tv[14] = '{1'b1,1'b0,1'b0,1'b0,32'h0,       32'h4,        32'hAB000004, 32'h4,        32'h8,        1'b1};
    tv[15] = '{1'b0,1'b0,1'b0,1'b0,32'h0,       32'h8,        32'hAB000004, 32'h4,        32'h8,        1'b1};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    #12;
    chk_idle_reset("rst0");
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(tv[i].sf, tv[i].sd, tv[i].fl, tv[i].br, tv[i].tgt);
      chk($sformatf("v%0d_addr", i),  bus.imem_addr, tv[i].addr);
      chk($sformatf("v%0d_instr", i), bus.instr_d, tv[i].instr);
      chk($sformatf("v%0d_pc", i),    bus.pc_d, tv[i].pc);
      chk($sformatf("v%0d_p4", i),    bus.pcplus4_d, tv[i].p4);
      chk($sformatf("v%0d_valid", i), {31'b0, bus.valid_d}, {31'b0, tv[i].v});
      chk($sformatf("v%0d_trap", i),  {31'b0, bus.misalign_trap}, 32'h0);
    end

    // reset mid-stream, then straight-line fetch up to PC 0x10
    reset = 1'b1;
    #2;
    chk_idle_reset("rst1");
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk($sformatf("sl%0d_addr", i), bus.imem_addr, 32'(4 * i));
      chk($sformatf("sl%0d_pc", i),   bus.pc_d, 32'(4 * (i - 1)));
      chk($sformatf("sl%0d_valid", i), {31'b0, bus.valid_d}, 32'h1);
    end

    // misaligned redirect at PC 0x10
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h42);
    chk("mis_addr",  bus.imem_addr, 32'h10);
    chk("mis_trap",  {31'b0, bus.misalign_trap}, 32'h1);
    chk("mis_valid", {31'b0, bus.valid_d}, 32'h0);
    chk("mis_instr", bus.instr_d, NOP);

    // inputs ignored while trapped
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
    chk("tr0_addr", bus.imem_addr, 32'h10);
    chk("tr0_trap", {31'b0, bus.misalign_trap}, 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("tr1_addr",  bus.imem_addr, 32'h10);
    chk("tr1_valid", {31'b0, bus.valid_d}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("tr2_addr",  bus.imem_addr, 32'h10);
    chk("tr2_valid", {31'b0, bus.valid_d}, 32'h0);
    chk("tr2_instr", bus.instr_d, NOP);
    chk("tr2_trap",  {31'b0, bus.misalign_trap}, 32'h1);

    // asynchronous reset out of TRAP, with stalls held during reset
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk_idle_reset("rst2");
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("post_addr",  bus.imem_addr, 32'h4);
    chk("post_instr", bus.instr_d, 32'hAB000000);
    chk("post_pc",    bus.pc_d, 32'h0);
    chk("post_p4",    bus.pcplus4_d, 32'h4);
    chk("post_valid", {31'b0, bus.valid_d}, 32'h1);
    chk("post_trap",  {31'b0, bus.misalign_trap}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
